// File: rtl/miriscv_lsu_pipe.sv
// Pipelined load-store unit: one op per cycle into an issue register, up to
// MAX_OUTSTANDING granted ops tracked in an in-order pending FIFO.
module miriscv_lsu_pipe #(
    parameter int XLEN            = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TAG_W           = 5,
    parameter int MISALIGN_TRAP   = 1
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              lsu_req_i,
    output logic              lsu_ready_o,
    input  logic              lsu_kill_i,
    input  logic              lsu_we_i,
    input  logic [2:0]        lsu_size_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_data_i,
    input  logic [TAG_W-1:0]  lsu_tag_i,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,
    output logic [TAG_W-1:0]  lsu_rtag_o,
    output logic              lsu_exc_o,
    output logic [XLEN-1:0]   lsu_exc_addr_o,
    output logic [TAG_W-1:0]  lsu_exc_tag_o,
    output logic              data_req_o,
    input  logic              data_gnt_i,
    output logic              data_we_o,
    output logic [XLEN/8-1:0] data_be_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic [XLEN-1:0]   data_wdata_o,
    input  logic              data_rvalid_i,
    input  logic [XLEN-1:0]   data_rdata_i
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    function automatic logic [3:0] calc_be(input logic [2:0] size, input logic [1:0] off);
        case (size[1:0])
            2'b00:   calc_be = 4'b0001 << off;
            2'b01:   calc_be = 4'b0011 << off;
            default: calc_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [2:0] size, input logic [31:0] d);
        case (size[1:0])
            2'b00:   calc_wdata = {4{d[7:0]}};
            2'b01:   calc_wdata = {2{d[15:0]}};
            default: calc_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] size, input logic [1:0] off,
                                            input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (size)
            3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
            3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
            3'b100:  extract = {24'b0, sh[7:0]};
            3'b101:  extract = {16'b0, sh[15:0]};
            default: extract = rd;
        endcase
    endfunction

    logic             iss_vld, iss_killed, rdy_en;
    logic [2:0]       iss_size;
    logic [1:0]       iss_off;
    logic [TAG_W-1:0] iss_tag;
    logic [PW-1:0]    wp, rp;
    logic [CW-1:0]    count;
    logic [CW:0]      occ;

    logic                       fifo_we   [MAX_OUTSTANDING];
    logic [2:0]                 fifo_size [MAX_OUTSTANDING];
    logic [1:0]                 fifo_off  [MAX_OUTSTANDING];
    logic [TAG_W-1:0]           fifo_tag  [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] fifo_killed;

    logic       fire, push, pop, accept, misal, illegal, trap, issue_new;
    logic [1:0] off_in, eff_off;

    assign fire = iss_vld & data_gnt_i;
    assign push = fire;
    assign pop  = data_rvalid_i & (count != '0);
    assign occ  = {1'b0, count} + (CW+1)'(iss_vld);

    // Ready depends only on flops plus data_gnt_i and kill; kill blocks acceptance.
    assign lsu_ready_o = rdy_en & ~lsu_kill_i & (~iss_vld | fire)
                       & (occ < (CW+1)'(MAX_OUTSTANDING));
    assign accept = lsu_req_i & lsu_ready_o;

    assign off_in  = lsu_addr_i[1:0];
    assign misal   = (lsu_size_i[1:0] == 2'b01 && off_in[0])
                   | (lsu_size_i[1:0] == 2'b10 && off_in != 2'b00);
    assign illegal = (lsu_size_i == 3'b011) | (lsu_size_i[2:1] == 2'b11)
                   | (lsu_we_i & lsu_size_i[2]);
    assign trap      = illegal | ((MISALIGN_TRAP != 0) & misal);
    assign issue_new = accept & ~trap;

    always_comb begin
        eff_off = off_in;
        case (lsu_size_i[1:0])
            2'b01:   eff_off = {off_in[1], 1'b0};
            2'b10:   eff_off = 2'b00;
            default: eff_off = off_in;
        endcase
    end

    assign data_req_o = iss_vld;

    // Issue register: bus fields come straight from these flops.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rdy_en       <= 1'b0;
            iss_vld      <= 1'b0;
            iss_killed   <= 1'b0;
            iss_size     <= '0;
            iss_off      <= '0;
            iss_tag      <= '0;
            data_we_o    <= 1'b0;
            data_be_o    <= '0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (fire)
                iss_vld <= 1'b0;
            if (lsu_kill_i)
                iss_killed <= 1'b1;
            if (issue_new) begin
                iss_vld      <= 1'b1;
                iss_killed   <= 1'b0;
                iss_size     <= lsu_size_i;
                iss_off      <= eff_off;
                iss_tag      <= lsu_tag_i;
                data_we_o    <= lsu_we_i;
                data_be_o    <= calc_be(lsu_size_i, eff_off);
                data_addr_o  <= {lsu_addr_i[XLEN-1:2], 2'b00};
                data_wdata_o <= calc_wdata(lsu_size_i, lsu_data_i);
            end
        end
    end

    // Pending FIFO control
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= (wp == PW'(MAX_OUTSTANDING-1)) ? '0 : wp + 1'b1;
            if (pop)
                rp <= (rp == PW'(MAX_OUTSTANDING-1)) ? '0 : rp + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    // FIFO payload; kill marks every stored entry, a same-cycle push inherits it.
    always_ff @(posedge clk_i) begin
        if (lsu_kill_i)
            fifo_killed <= '1;
        if (push) begin
            fifo_we[wp]     <= data_we_o;
            fifo_size[wp]   <= iss_size;
            fifo_off[wp]    <= iss_off;
            fifo_tag[wp]    <= iss_tag;
            fifo_killed[wp] <= iss_killed | lsu_kill_i;
        end
    end

    // Response and exception registers
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lsu_rvalid_o   <= 1'b0;
            lsu_rdata_o    <= '0;
            lsu_rtag_o     <= '0;
            lsu_exc_o      <= 1'b0;
            lsu_exc_addr_o <= '0;
            lsu_exc_tag_o  <= '0;
        end else begin
            lsu_rvalid_o <= pop & ~fifo_killed[rp] & ~lsu_kill_i;
            if (pop) begin
                lsu_rtag_o  <= fifo_tag[rp];
                lsu_rdata_o <= fifo_we[rp] ? '0 : extract(fifo_size[rp], fifo_off[rp], data_rdata_i);
            end
            lsu_exc_o <= accept & trap;
            if (accept && trap) begin
                lsu_exc_addr_o <= lsu_addr_i;
                lsu_exc_tag_o  <= lsu_tag_i;
            end
        end
    end
endmodule

// File: tb/tb_miriscv_lsu_pipe.sv
// Directed bench for miriscv_lsu_pipe with default parameters
// (MAX_OUTSTANDING=2, MISALIGN_TRAP=1).
module tb_miriscv_lsu_pipe;
    logic        clk = 1'b0;
    logic        arstn;
    logic        lsu_req, lsu_ready, lsu_kill, lsu_we;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_data;
    logic [4:0]  lsu_tag;
    logic        lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [4:0]  lsu_rtag;
    logic        lsu_exc;
    logic [31:0] lsu_exc_addr;
    logic [4:0]  lsu_exc_tag;
    logic        data_req, data_gnt, data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    miriscv_lsu_pipe dut (
        .clk_i(clk), .arstn_i(arstn),
        .lsu_req_i(lsu_req), .lsu_ready_o(lsu_ready), .lsu_kill_i(lsu_kill),
        .lsu_we_i(lsu_we), .lsu_size_i(lsu_size), .lsu_addr_i(lsu_addr),
        .lsu_data_i(lsu_data), .lsu_tag_i(lsu_tag),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata), .lsu_rtag_o(lsu_rtag),
        .lsu_exc_o(lsu_exc), .lsu_exc_addr_o(lsu_exc_addr), .lsu_exc_tag_o(lsu_exc_tag),
        .data_req_o(data_req), .data_gnt_i(data_gnt), .data_we_o(data_we),
        .data_be_o(data_be), .data_addr_o(data_addr), .data_wdata_o(data_wdata),
        .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] data, input logic [4:0] tag);
        lsu_req  = 1'b1;
        lsu_we   = we;
        lsu_size = size;
        lsu_addr = addr;
        lsu_data = data;
        lsu_tag  = tag;
    endtask

    // Present an op, let it be accepted, then go idle; bus fields are visible on return.
    task automatic issue(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] tag);
        op(we, size, addr, data, tag);
        tick();
        lsu_req = 1'b0;
    endtask

    // Let the grant land, then deliver one bus response; lsu outputs visible on return.
    task automatic resp(input logic [31:0] rdata);
        tick();
        data_rvalid = 1'b1;
        data_rdata  = rdata;
        tick();
        data_rvalid = 1'b0;
    endtask

    initial begin
        arstn = 1'b0; lsu_req = 1'b0; lsu_kill = 1'b0; lsu_we = 1'b0; lsu_size = 3'b010;
        lsu_addr = '0; lsu_data = '0; lsu_tag = '0;
        data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        tick(); tick();
        chk("rst_rvalid", {31'b0, lsu_rvalid}, 32'h0);
        chk("rst_ready",  {31'b0, lsu_ready},  32'h0);
        chk("rst_req",    {31'b0, data_req},   32'h0);
        chk("rst_exc",    {31'b0, lsu_exc},    32'h0);
        chk("rst_be",     {28'b0, data_be},    32'h0);
        arstn = 1'b1;
        tick();
        chk("ready_after_rst", {31'b0, lsu_ready}, 32'h1);

        // LW basic
        data_gnt = 1'b1;
        op(1'b0, 3'b010, 32'h100, 32'h0, 5'd3);
        #1 chk("lw_ready", {31'b0, lsu_ready}, 32'h1);
        tick();
        lsu_req = 1'b0;
        chk("lw_req",  {31'b0, data_req}, 32'h1);
        chk("lw_be",   {28'b0, data_be},  32'hF);
        chk("lw_addr", data_addr,          32'h100);
        chk("lw_we",   {31'b0, data_we},  32'h0);
        tick();
        chk("lw_req_drop", {31'b0, data_req}, 32'h0);
        tick();
        data_rvalid = 1'b1; data_rdata = 32'hDEADBEEF;
        tick();
        data_rvalid = 1'b0;
        chk("lw_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("lw_rdata",  lsu_rdata,            32'hDEADBEEF);
        chk("lw_rtag",   {27'b0, lsu_rtag},   32'd3);
        tick();
        chk("lw_rvalid_drop", {31'b0, lsu_rvalid}, 32'h0);

        // Sub-word loads and stores
        issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd4);
        chk("lb_be",   {28'b0, data_be}, 32'h8);
        chk("lb_addr", data_addr,         32'h100);
        resp(32'h80112233);
        chk("lb_rdata", lsu_rdata,          32'hFFFFFF80);
        chk("lb_rtag",  {27'b0, lsu_rtag}, 32'd4);
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd5);
        resp(32'h80112233);
        chk("lbu_rdata", lsu_rdata, 32'h00000080);
        issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd6);
        chk("lh_be", {28'b0, data_be}, 32'hC);
        resp(32'h80112233);
        chk("lh_rdata", lsu_rdata, 32'hFFFF8011);
        issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd6);
        resp(32'h80112233);
        chk("lhu_rdata", lsu_rdata, 32'h00008011);
        issue(1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd8);
        chk("sh_be",    {28'b0, data_be}, 32'hC);
        chk("sh_wdata", data_wdata,        32'hABCDABCD);
        chk("sh_we",    {31'b0, data_we}, 32'h1);
        chk("sh_addr",  data_addr,         32'h100);
        resp(32'h12345678);
        chk("sh_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("sh_rdata",  lsu_rdata,            32'h0);
        chk("sh_rtag",   {27'b0, lsu_rtag},   32'd8);
        issue(1'b1, 3'b000, 32'h101, 32'h000000A5, 5'd9);
        chk("sb_be",    {28'b0, data_be}, 32'h2);
        chk("sb_wdata", data_wdata,        32'hA5A5A5A5);
        resp(32'h0);

        // Outstanding limit with responses withheld
        op(1'b0, 3'b010, 32'h400, 32'h0, 5'd10);
        #1 chk("bp_ready_a", {31'b0, lsu_ready}, 32'h1);
        tick();
        op(1'b0, 3'b010, 32'h404, 32'h0, 5'd11);
        #1 chk("bp_ready_b", {31'b0, lsu_ready}, 32'h1);
        tick();
        op(1'b0, 3'b010, 32'h408, 32'h0, 5'd12);
        #1 chk("bp_ready_c0", {31'b0, lsu_ready}, 32'h1 ^ 32'h1);
        tick();
        chk("bp_req_idle", {31'b0, data_req},  32'h0);
        chk("bp_ready_c1", {31'b0, lsu_ready}, 32'h0);
        tick();
        chk("bp_req_idle2", {31'b0, data_req},  32'h0);
        chk("bp_ready_c2",  {31'b0, lsu_ready}, 32'h0);
        data_rvalid = 1'b1; data_rdata = 32'h11111111;
        #1 chk("bp_no_rvalid_path", {31'b0, lsu_ready}, 32'h0);
        tick();
        data_rvalid = 1'b0;
        chk("bp_rtag_a",   {27'b0, lsu_rtag},   32'd10);
        chk("bp_rvalid_a", {31'b0, lsu_rvalid}, 32'h1);
        chk("bp_ready_c3", {31'b0, lsu_ready},  32'h1);
        tick();
        lsu_req = 1'b0;
        chk("bp_req_c",  {31'b0, data_req}, 32'h1);
        chk("bp_addr_c", data_addr,          32'h408);
        data_rvalid = 1'b1; data_rdata = 32'h22222222;
        tick();
        chk("bp_rtag_b",  {27'b0, lsu_rtag}, 32'd11);
        chk("bp_rdata_b", lsu_rdata,          32'h22222222);
        data_rdata = 32'h33333333;
        tick();
        data_rvalid = 1'b0;
        chk("bp_rtag_c",  {27'b0, lsu_rtag}, 32'd12);
        chk("bp_rdata_c", lsu_rdata,          32'h33333333);
        tick();
        chk("bp_quiet", {31'b0, lsu_rvalid}, 32'h0);
        chk("bp_ready_end", {31'b0, lsu_ready}, 32'h1);

        // Misaligned word and illegal-size store
        issue(1'b0, 3'b010, 32'h101, 32'h0, 5'd7);
        chk("mis_exc",      {31'b0, lsu_exc},     32'h1);
        chk("mis_exc_addr", lsu_exc_addr,          32'h101);
        chk("mis_exc_tag",  {27'b0, lsu_exc_tag}, 32'd7);
        chk("mis_no_req",   {31'b0, data_req},    32'h0);
        tick();
        chk("mis_exc_drop",  {31'b0, lsu_exc},    32'h0);
        chk("mis_no_rvalid", {31'b0, lsu_rvalid}, 32'h0);
        issue(1'b1, 3'b100, 32'h20, 32'h0, 5'd13);
        chk("ill_exc",     {31'b0, lsu_exc},     32'h1);
        chk("ill_exc_tag", {27'b0, lsu_exc_tag}, 32'd13);
        chk("ill_no_req",  {31'b0, data_req},    32'h0);
        tick();
        chk("ill_no_rvalid", {31'b0, lsu_rvalid}, 32'h0);

        // Kill with request on an empty unit: not accepted
        op(1'b0, 3'b010, 32'h500, 32'h0, 5'd14);
        lsu_kill = 1'b1;
        #1 chk("kill_ready", {31'b0, lsu_ready}, 32'h0);
        tick();
        lsu_kill = 1'b0; lsu_req = 1'b0;
        chk("kill_no_req", {31'b0, data_req}, 32'h0);

        // Kill with one op granted and one waiting for grant
        op(1'b0, 3'b010, 32'h200, 32'h0, 5'd1);
        tick();
        op(1'b0, 3'b010, 32'h204, 32'h0, 5'd2);
        tick();
        lsu_req = 1'b0; data_gnt = 1'b0;
        chk("kl_req_b", {31'b0, data_req}, 32'h1);
        lsu_kill = 1'b1;
        tick();
        lsu_kill = 1'b0;
        chk("kl_req_hold", {31'b0, data_req}, 32'h1);
        chk("kl_addr_hold", data_addr,         32'h204);
        tick();
        chk("kl_req_hold2", {31'b0, data_req}, 32'h1);
        data_gnt = 1'b1;
        tick();
        chk("kl_req_done", {31'b0, data_req}, 32'h0);
        data_rvalid = 1'b1; data_rdata = 32'hAAAAAAAA;
        tick();
        chk("kl_silent_a", {31'b0, lsu_rvalid}, 32'h0);
        tick();
        data_rvalid = 1'b0;
        chk("kl_silent_b", {31'b0, lsu_rvalid}, 32'h0);
        issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
        resp(32'hCAFEF00D);
        chk("kl_next_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("kl_next_rtag",   {27'b0, lsu_rtag},   32'd9);
        chk("kl_next_rdata",  lsu_rdata,            32'hCAFEF00D);

        // Reset with two ops pending, then stale responses
        op(1'b0, 3'b010, 32'h600, 32'h0, 5'd20);
        tick();
        op(1'b0, 3'b010, 32'h604, 32'h0, 5'd21);
        tick();
        lsu_req = 1'b0;
        tick();
        arstn = 1'b0;
        #1 chk("mr_req",   {31'b0, data_req},  32'h0);
        chk("mr_ready", {31'b0, lsu_ready}, 32'h0);
        tick();
        arstn = 1'b1;
        tick();
        data_rvalid = 1'b1; data_rdata = 32'h55555555;
        tick();
        chk("mr_stale_a", {31'b0, lsu_rvalid}, 32'h0);
        tick();
        data_rvalid = 1'b0;
        chk("mr_stale_b", {31'b0, lsu_rvalid}, 32'h0);
        chk("mr_ready_up", {31'b0, lsu_ready}, 32'h1);
        issue(1'b0, 3'b010, 32'h700, 32'h0, 5'd22);
        resp(32'h77777777);
        chk("mr_next_rvalid", {31'b0, lsu_rvalid}, 32'h1);
        chk("mr_next_rtag",   {27'b0, lsu_rtag},   32'd22);
        chk("mr_next_rdata",  lsu_rdata,            32'h77777777);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
